// File: rtl/lut_table_if.sv
// Load-stream and read-port bundle for lut_table.
// The master side drives loads and read requests; the table is the slave.
interface lut_table_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned NUM_RD = 2
);
  logic                     clear;
  logic                     ld_start;
  logic [ADDR_W-1:0]        ld_base;
  logic [ADDR_W:0]          ld_count;
  logic                     ld_valid;
  logic [DATA_W-1:0]        ld_data;
  logic                     ld_ready;
  logic                     ld_busy;
  logic                     ld_done;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_miss;

  modport master (
    output clear, ld_start, ld_base, ld_count, ld_valid, ld_data, rd_en, rd_addr,
    input  ld_ready, ld_busy, ld_done, rd_data, rd_valid, rd_miss
  );

  modport slave (
    input  clear, ld_start, ld_base, ld_count, ld_valid, ld_data, rd_en, rd_addr,
    output ld_ready, ld_busy, ld_done, rd_data, rd_valid, rd_miss
  );
endinterface

// File: rtl/lut_table.sv
// Writable lookup table: burst-loaded through a valid/ready stream, NUM_RD registered
// read ports with per-entry valid tracking, write-through bypass and a miss flag.
module lut_table #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned NUM_RD      = 2,
  parameter int unsigned DEFAULT_VAL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  lut_table_if.slave bus
);

  localparam int unsigned       Depth    = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] DefVal   = DATA_W'(DEFAULT_VAL);
  localparam logic [ADDR_W:0]   RemainOne = (ADDR_W + 1)'(1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        ptr_q, ptr_d;
  logic [ADDR_W:0]          remain_q, remain_d;
  logic [DATA_W-1:0]        mem [Depth];
  logic [Depth-1:0]         valid_q, valid_d;
  logic                     wr_en;
  logic [ADDR_W-1:0]        rd_addr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_miss_q, rd_miss_d;
  logic [NUM_RD-1:0]        rd_valid_q;

  assign wr_en = (state_q == StLoad) && bus.ld_valid;

  // Load FSM
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    remain_d = remain_q;
    case (state_q)
      StIdle: begin
        if (bus.ld_start) begin
          if (bus.ld_count != '0) begin
            ptr_d    = bus.ld_base;
            remain_d = bus.ld_count;
            state_d  = StLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        if (bus.ld_valid) begin
          ptr_d    = ptr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == RemainOne) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Clear first so a concurrent load write leaves its own entry valid.
  always_comb begin
    valid_d = valid_q;
    if (bus.clear) begin
      valid_d = '0;
    end
    if (wr_en) begin
      valid_d[ptr_q] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr[i] = bus.rd_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Priority: same-cycle load write, then clear, then stored valid bit.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_miss_d = rd_miss_q;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_en[i]) begin
        if (wr_en && (rd_addr[i] == ptr_q)) begin
          rd_data_d[i*DATA_W +: DATA_W] = bus.ld_data;
          rd_miss_d[i]                  = 1'b0;
        end else if (!bus.clear && valid_q[rd_addr[i]]) begin
          rd_data_d[i*DATA_W +: DATA_W] = mem[rd_addr[i]];
          rd_miss_d[i]                  = 1'b0;
        end else begin
          rd_data_d[i*DATA_W +: DATA_W] = DefVal;
          rd_miss_d[i]                  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      remain_q   <= '0;
      valid_q    <= '0;
      rd_data_q  <= '0;
      rd_miss_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      valid_q    <= valid_d;
      rd_data_q  <= rd_data_d;
      rd_miss_q  <= rd_miss_d;
      rd_valid_q <= bus.rd_en;
    end
  end

  // Entry storage is deliberately not reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q] <= bus.ld_data;
    end
  end

  assign bus.ld_ready = (state_q == StLoad);
  assign bus.ld_busy  = (state_q != StIdle);
  assign bus.ld_done  = (state_q == StDone);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_miss  = rd_miss_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_lut_table.sv
// Self-checking bench for lut_table: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the table and its burst protocol.
module tb_lut_table;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 10;
  localparam int unsigned NR = 2;
  localparam int unsigned DEFV = 1;
  localparam int DEPTH = 32;
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DONE = 2;

  logic clk = 1'b0;
  logic rst_n;

  lut_table_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR)) bus ();

  lut_table #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .DEFAULT_VAL(DEFV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model
  int m_mem[DEPTH];
  bit m_vld[DEPTH];
  int m_phase, m_ptr, m_remain;
  int exp_data[NR];
  bit exp_miss[NR];
  bit exp_rv[NR];

  task automatic model_reset();
    foreach (m_vld[k]) m_vld[k] = 1'b0;
    m_phase = PH_IDLE; m_ptr = 0; m_remain = 0;
    for (int p = 0; p < int'(NR); p++) begin
      exp_data[p] = 0; exp_miss[p] = 1'b0; exp_rv[p] = 1'b0;
    end
  endtask

  task automatic set_idle();
    bus.clear = 1'b0; bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_count = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.rd_en = '0; bus.rd_addr = '0;
  endtask

  task automatic set_rd(input int p, input int addr);
    bus.rd_en[p] = 1'b1;
    bus.rd_addr[p*AW +: AW] = AW'(addr);
  endtask

  task automatic start_burst(input int base, input int count);
    bus.ld_start = 1'b1; bus.ld_base = AW'(base); bus.ld_count = (AW + 1)'(count);
  endtask

  // Advance one clock: predict this edge's effects from the current inputs, then sample at negedge.
  task automatic tick();
    bit wr;
    int wa, a, nph;
    wr = (m_phase == PH_LOAD) && (bus.ld_valid === 1'b1);
    wa = m_ptr;
    for (int p = 0; p < int'(NR); p++) begin
      if (bus.rd_en[p] === 1'b1) begin
        a = int'(bus.rd_addr[p*AW +: AW]);
        exp_rv[p] = 1'b1;
        if (wr && wa == a) begin
          exp_data[p] = int'(bus.ld_data); exp_miss[p] = 1'b0;
        end else if (bus.clear === 1'b1 || !m_vld[a]) begin
          exp_data[p] = DEFV; exp_miss[p] = 1'b1;
        end else begin
          exp_data[p] = m_mem[a]; exp_miss[p] = 1'b0;
        end
      end else begin
        exp_rv[p] = 1'b0;
      end
    end
    if (bus.clear === 1'b1) foreach (m_vld[k]) m_vld[k] = 1'b0;
    nph = m_phase;
    if (m_phase == PH_IDLE) begin
      if (bus.ld_start === 1'b1) begin
        if (bus.ld_count != 0) begin
          nph = PH_LOAD; m_ptr = int'(bus.ld_base); m_remain = int'(bus.ld_count);
        end else begin
          nph = PH_DONE;
        end
      end
    end else if (m_phase == PH_LOAD) begin
      if (wr) begin
        m_mem[wa] = int'(bus.ld_data); m_vld[wa] = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH; m_remain = m_remain - 1;
        if (m_remain == 0) nph = PH_DONE;
      end
    end else begin
      nph = PH_IDLE;
    end
    m_phase = nph;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.ld_ready, bus.ld_busy, bus.ld_done} !== 3'b000) begin
      bad++; $display("FAIL reset_ld: got rdy/busy/done=%b want 000",
                      {bus.ld_ready, bus.ld_busy, bus.ld_done});
    end
    total++;
    if (bus.rd_valid !== '0 || bus.rd_miss !== '0 || bus.rd_data !== '0) begin
      bad++; $display("FAIL reset_rd: got v=%b m=%b d=%h want all zero",
                      bus.rd_valid, bus.rd_miss, bus.rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      set_rd(0, s == 0 ? 0 : 31);
      set_rd(1, s == 0 ? 31 : 0);
      tick();
      set_idle();
      for (int p = 0; p < int'(NR); p++) begin
        total++;
        if (bus.rd_valid[p] !== 1'b1 || bus.rd_miss[p] !== 1'b1 ||
            bus.rd_data[p*DW +: DW] !== 10'h001) begin
          bad++; $display("FAIL reset_read port%0d: got v=%b m=%b d=%0d want v=1 m=1 d=1",
                          p, bus.rd_valid[p], bus.rd_miss[p], bus.rd_data[p*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_load_gap();
    int words[3] = '{96, 72, 120};
    bit vpat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int ready_cnt = 0;
    int wi = 0;
    start_burst(0, 3);
    tick();
    set_idle();
    for (int k = 0; k < 4; k++) begin
      if (bus.ld_ready === 1'b1) ready_cnt++;
      bus.ld_valid = vpat[k];
      bus.ld_data  = DW'(words[wi]);
      if (vpat[k]) wi++;
      tick();
      set_idle();
    end
    total++;
    if (ready_cnt != 4) begin
      bad++; $display("FAIL load_ready_cycles: got %0d want 4", ready_cnt);
    end
    total++;
    if ({bus.ld_ready, bus.ld_busy, bus.ld_done} !== 3'b011) begin
      bad++; $display("FAIL load_done: got rdy/busy/done=%b want 011",
                      {bus.ld_ready, bus.ld_busy, bus.ld_done});
    end
    tick();
    total++;
    if ({bus.ld_busy, bus.ld_done} !== 2'b00) begin
      bad++; $display("FAIL load_idle: got busy/done=%b want 00", {bus.ld_busy, bus.ld_done});
    end
    set_rd(0, 0); set_rd(1, 1);
    tick();
    set_idle();
    total++;
    if (bus.rd_data[0 +: DW] !== 10'd96 || bus.rd_data[DW +: DW] !== 10'd72 ||
        bus.rd_miss !== 2'b00 || bus.rd_valid !== 2'b11) begin
      bad++; $display("FAIL load_read01: got d0=%0d d1=%0d m=%b v=%b want 96 72 00 11",
                      bus.rd_data[0 +: DW], bus.rd_data[DW +: DW], bus.rd_miss, bus.rd_valid);
    end
    set_rd(0, 2);
    tick();
    set_idle();
    total++;
    if (bus.rd_data[0 +: DW] !== 10'd120 || bus.rd_valid !== 2'b01 ||
        bus.rd_data[DW +: DW] !== 10'd72 || bus.rd_miss !== 2'b00) begin
      bad++; $display("FAIL load_read2_hold: got d0=%0d d1=%0d v=%b m=%b want 120 72 01 00",
                      bus.rd_data[0 +: DW], bus.rd_data[DW +: DW], bus.rd_valid, bus.rd_miss);
    end
  endtask

  task automatic test_wrap();
    int words[4] = '{41, 81, 51, 135};
    start_burst(30, 4);
    tick();
    set_idle();
    for (int k = 0; k < 4; k++) begin
      bus.ld_valid = 1'b1; bus.ld_data = DW'(words[k]);
      tick();
      set_idle();
    end
    tick();
    for (int s = 0; s < 2; s++) begin
      set_rd(0, s == 0 ? 0 : 30);
      set_rd(1, s == 0 ? 1 : 31);
      tick();
      set_idle();
      for (int p = 0; p < int'(NR); p++) begin
        total++;
        if (bus.rd_data[p*DW +: DW] !== DW'(exp_data[p]) || bus.rd_miss[p] !== 1'b0 ||
            exp_data[p] != words[(s == 0 ? 2 : 0) + p]) begin
          bad++; $display("FAIL wrap_read s%0d port%0d: got d=%0d m=%b want d=%0d m=0",
                          s, p, bus.rd_data[p*DW +: DW], bus.rd_miss[p],
                          words[(s == 0 ? 2 : 0) + p]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    start_burst(5, 1);
    tick();
    set_idle();
    bus.ld_valid = 1'b1; bus.ld_data = 10'd91;
    set_rd(0, 5); set_rd(1, 6);
    tick();
    set_idle();
    total++;
    if (bus.rd_data[0 +: DW] !== 10'd91 || bus.rd_miss[0] !== 1'b0) begin
      bad++; $display("FAIL bypass_hit: got d=%0d m=%b want d=91 m=0",
                      bus.rd_data[0 +: DW], bus.rd_miss[0]);
    end
    total++;
    if (bus.rd_data[DW +: DW] !== DW'(DEFV) || bus.rd_miss[1] !== 1'b1) begin
      bad++; $display("FAIL bypass_other: got d=%0d m=%b want d=%0d m=1",
                      bus.rd_data[DW +: DW], bus.rd_miss[1], DEFV);
    end
    tick();
  endtask

  task automatic test_clear();
    start_burst(2, 1);
    tick();
    set_idle();
    bus.ld_valid = 1'b1; bus.ld_data = 10'd125; bus.clear = 1'b1;
    tick();
    set_idle();
    tick();
    set_rd(0, 2); set_rd(1, 0);
    tick();
    set_idle();
    total++;
    if (bus.rd_data[0 +: DW] !== 10'd125 || bus.rd_miss[0] !== 1'b0) begin
      bad++; $display("FAIL clear_written: got d=%0d m=%b want d=125 m=0",
                      bus.rd_data[0 +: DW], bus.rd_miss[0]);
    end
    total++;
    if (bus.rd_data[DW +: DW] !== DW'(DEFV) || bus.rd_miss[1] !== 1'b1) begin
      bad++; $display("FAIL clear_other: got d=%0d m=%b want d=%0d m=1",
                      bus.rd_data[DW +: DW], bus.rd_miss[1], DEFV);
    end
  endtask

  task automatic test_reset_midburst();
    int done_seen = 0;
    start_burst(10, 5);
    tick();
    set_idle();
    for (int k = 0; k < 2; k++) begin
      bus.ld_valid = 1'b1; bus.ld_data = DW'(200 + k);
      tick();
      set_idle();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({bus.ld_ready, bus.ld_busy, bus.ld_done, bus.rd_valid} !== 5'b00000) begin
      bad++; $display("FAIL midreset_async: got rdy/busy/done/rv=%b want 00000",
                      {bus.ld_ready, bus.ld_busy, bus.ld_done, bus.rd_valid});
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (bus.ld_done !== 1'b0 || bus.ld_ready !== 1'b0) done_seen++;
      tick();
    end
    total++;
    if (done_seen != 0) begin
      bad++; $display("FAIL midreset_nodone: got %0d cycles with done/ready want 0", done_seen);
    end
    set_rd(0, 10); set_rd(1, 11);
    tick();
    set_idle();
    total++;
    if (bus.rd_miss !== 2'b11 || bus.rd_data[0 +: DW] !== DW'(DEFV) ||
        bus.rd_data[DW +: DW] !== DW'(DEFV)) begin
      bad++; $display("FAIL midreset_read: got m=%b d0=%0d d1=%0d want m=11 d=%0d",
                      bus.rd_miss, bus.rd_data[0 +: DW], bus.rd_data[DW +: DW], DEFV);
    end
    start_burst(0, 0);
    tick();
    set_idle();
    total++;
    if ({bus.ld_ready, bus.ld_busy, bus.ld_done} !== 3'b011) begin
      bad++; $display("FAIL empty_burst_done: got rdy/busy/done=%b want 011",
                      {bus.ld_ready, bus.ld_busy, bus.ld_done});
    end
    tick();
    total++;
    if ({bus.ld_busy, bus.ld_done} !== 2'b00) begin
      bad++; $display("FAIL empty_burst_idle: got busy/done=%b want 00",
                      {bus.ld_busy, bus.ld_done});
    end
  endtask

  task automatic test_random();
    int a0;
    for (int c = 0; c < 600; c++) begin
      set_idle();
      bus.ld_start = ($urandom_range(0, 9) < 2);
      bus.ld_base  = AW'($urandom_range(0, DEPTH - 1));
      bus.ld_count = (AW + 1)'($urandom_range(0, 40));
      bus.ld_valid = ($urandom_range(0, 3) != 0);
      bus.ld_data  = DW'($urandom);
      bus.clear    = ($urandom_range(0, 29) == 0);
      bus.rd_en    = NR'($urandom);
      a0 = ($urandom_range(0, 3) == 0) ? m_ptr : int'($urandom_range(0, DEPTH - 1));
      bus.rd_addr[0 +: AW] = AW'(a0);
      bus.rd_addr[AW +: AW] = ($urandom_range(0, 2) == 0) ? AW'(a0) : AW'($urandom);
      tick();
      total++;
      if ({bus.ld_ready, bus.ld_busy, bus.ld_done} !==
          {m_phase == PH_LOAD, m_phase != PH_IDLE, m_phase == PH_DONE}) begin
        bad++; $display("FAIL rand_ld c%0d: got rdy/busy/done=%b want phase %0d",
                        c, {bus.ld_ready, bus.ld_busy, bus.ld_done}, m_phase);
      end
      for (int p = 0; p < int'(NR); p++) begin
        total++;
        if (bus.rd_valid[p] !== exp_rv[p] || bus.rd_miss[p] !== exp_miss[p] ||
            bus.rd_data[p*DW +: DW] !== DW'(exp_data[p])) begin
          bad++; $display("FAIL rand_rd c%0d port%0d: got v=%b m=%b d=%0d want v=%b m=%b d=%0d",
                          c, p, bus.rd_valid[p], bus.rd_miss[p], bus.rd_data[p*DW +: DW],
                          exp_rv[p], exp_miss[p], exp_data[p]);
        end
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_gap();
    test_wrap();
    test_bypass();
    test_clear();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/lut_table.md
# lut_table

Parametrised, writable lookup table for the PC-target / tap-pattern / constant path. Replaces the fixed constant case table: entries are bulk-loaded at run time through a valid/ready stream, so branch targets and constants for any program can be installed without changing RTL. Provides NUM_RD independent registered read ports with per-entry valid tracking, write-through bypass and a miss flag for unprogrammed entries.

## Interface
- ADDR_W, 5, index width; depth = 2^ADDR_W entries
- DATA_W, 10, entry width
- NUM_RD, 2, number of read ports
- DEFAULT_VAL, 1, value returned on a miss (DATA_W bits)

- Clk  in  1  clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Clear  in  1  invalidate all entries this cycle
- Ld_start  in  1  begin burst load (sampled only in IDLE)
- Ld_base  in  ADDR_W  first entry written by the burst
- Ld_count  in  ADDR_W+1  words in burst; 0 = empty burst
- Ld_valid  in  1  Ld_data valid
- Ld_data  in  DATA_W  entry value
- Ld_ready  out  1  block accepts Ld_data this cycle
- Ld_busy  out  1  burst in progress (LOAD or DONE)
- Ld_done  out  1  one-cycle pulse, burst complete
- Rd_en  in  NUM_RD  per-port read request
- Rd_addr  in  NUM_RD*ADDR_W  port i at bits [i*ADDR_W +: ADDR_W]
- Rd_data  out  NUM_RD*DATA_W  port i at bits [i*DATA_W +: DATA_W]
- Rd_valid  out  NUM_RD  Rd_data/Rd_miss for port i valid
- Rd_miss  out  NUM_RD  port i read an unprogrammed entry

## Operation
- Storage: 2^ADDR_W x DATA_W array (contents not reset) plus 2^ADDR_W valid bits (reset to 0).
- Load FSM states IDLE, LOAD, DONE.
  - IDLE: Ld_ready=0, Ld_busy=0. Ld_start=1 with Ld_count!=0: ptr<=Ld_base, remain<=Ld_count, go LOAD. Ld_start=1 with Ld_count=0: go DONE.
  - LOAD: Ld_ready=1. Accept when Ld_valid&Ld_ready: mem[ptr]<=Ld_data, valid[ptr]<=1, ptr<=ptr+1 mod 2^ADDR_W, remain<=remain-1. Accept with remain==1: go DONE. Ld_valid=0: stall, no state change.
  - DONE: Ld_done=1 for exactly one cycle, go IDLE.
- Ld_start outside IDLE ignored. Ld_count > 2^ADDR_W: ptr wraps; later words overwrite earlier ones.
- Clear: all valid bits <= 0. Same cycle as a load write: cleared everywhere except the written entry, which ends valid. Clear does not affect FSM; a burst in progress continues.
- Reads (per port, independent): on Rd_en[i], next cycle Rd_valid[i]=1 and
  - entry valid: Rd_data=mem[addr], Rd_miss=0;
  - entry invalid: Rd_data=DEFAULT_VAL, Rd_miss=1.
  - Write-through: load write to the same address in the same cycle returns Ld_data, Rd_miss=0 (also overrides a concurrent Clear).
  - Clear without same-address write in the read cycle: Rd_miss=1, DEFAULT_VAL.
- Rd_en[i]=0: Rd_valid[i]=0, Rd_data/Rd_miss for port i hold previous values.
- Multiple ports may read the same address in the same cycle; all return identical results.

## Timing
- Reset (Reset_n=0, async): state IDLE, all valid bits 0, ptr/remain 0, Ld_ready=0, Ld_busy=0, Ld_done=0, Rd_valid=0, Rd_miss=0, Rd_data=0.
- Reset mid-burst: burst aborted, no Ld_done; entries already written remain invalid (valid bits cleared).
- Ld_start accepted at edge t: Ld_ready=1 from cycle t+1.
- Throughput 1 word/cycle. Last word accepted at edge t: Ld_done=1 in cycle t+1, Ld_busy=0 and new Ld_start accepted in cycle t+2.
- Empty burst: Ld_done one cycle after Ld_start.
- Read latency 1 cycle; a word accepted at edge t is readable by a Rd_en sampled at edge t (bypass) or later.

## Test plan
- Reset, then read addr 0 and 31 on both ports -> Rd_valid=1, Rd_miss=1, Rd_data=10'h001.
- Load base 0, count 3, data 96,72,120 with one Ld_valid gap -> Ld_ready high 4 cycles, Ld_done one cycle after third accept; reads return 96,72,120, miss=0.
- Load base 30, count 4, data 41,81,51,135 -> entries 30,31,0,1 written (wrap); read 0 -> 51, read 1 -> 135.
- Read addr 5 on port 0 in the same cycle that 5 is written with 91 -> next cycle Rd_data=91, Rd_miss=0; port 1 reading addr 6 (unwritten) -> miss=1.
- Clear asserted in the same cycle as writing 125 to addr 2 -> addr 2 reads 125, previously loaded addr 0 reads DEFAULT_VAL with miss=1.
- Deassert Reset_n after 2 of 5 words -> Ld_ready=0, no Ld_done, both written entries read miss=1; a new Ld_start with count 0 -> Ld_done one cycle later.
